// File: rtl/pkt_tx_if.sv
// pkt_tx_if: source pop port plus downstream FIFO write port and its overflow flag.
// master is the transmitter side, slave is the source/FIFO side.
interface pkt_tx_if #(
    parameter int data_width = 64
);
    logic                  src_rd;
    logic [data_width-1:0] src_data;
    logic                  ovf;
    logic                  wr_sop;
    logic                  wr_eop;
    logic                  wr_vld;
    logic [data_width-1:0] wr_data;

    modport master (
        output src_rd, wr_sop, wr_eop, wr_vld, wr_data,
        input  src_data, ovf
    );

    modport slave (
        input  src_rd, wr_sop, wr_eop, wr_vld, wr_data,
        output src_data, ovf
    );
endinterface

// File: rtl/pkt_tx.sv
// pkt_tx: frames popped source words into sop/vld/eop packets; halts at a packet boundary on ovf.
// Define PKT_TX_LEN_HDR_EN to send pkt_len as a header word right after SOP.
module pkt_tx #(
    parameter int data_width = 64,
    parameter int len_width  = 9,
    parameter int gap_cycles = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [len_width-1:0] pkt_len,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    pkt_tx_if.master             bus
);

`ifdef PKT_TX_LEN_HDR_EN
    localparam bit hdr_en = 1'b1;
`else
    localparam bit hdr_en = 1'b0;
`endif

    // state | meaning
    // IDLE  | waiting for start; ovf here halts immediately
    // SOP   | wr_sop cycle; first pop (or header word queued when enabled)
    // DATA  | one wr_vld per popped word; leaves once no pops remain
    // EOP   | wr_eop and done
    // GAP   | gap_cycles of busy with no framing
    // HALT  | err set, start ignored until reset
    typedef enum logic [2:0] {
        S_IDLE,
        S_SOP,
        S_DATA,
        S_EOP,
        S_GAP,
        S_HALT
    } state_t;

    state_t                state_q;
    logic [len_width-1:0]  cnt_q;
    logic [len_width-1:0]  len_q;
    logic                  ovf_seen_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_q;
    logic                  wr_sop_q;
    logic                  wr_eop_q;
    logic                  wr_vld_q;
    logic [data_width-1:0] wr_data_q;
    logic                  pop;

    // cnt_q counts pops still owed while framing and remaining idle cycles in GAP
    assign pop = ((state_q == S_SOP && !hdr_en) || state_q == S_DATA) && (cnt_q != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            ovf_seen_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            wr_sop_q   <= 1'b0;
            wr_eop_q   <= 1'b0;
            wr_vld_q   <= 1'b0;
            wr_data_q  <= '0;
        end else begin
            wr_sop_q <= 1'b0;
            wr_eop_q <= 1'b0;
            done_q   <= 1'b0;
            wr_vld_q <= pop;
            if (pop) begin
                wr_data_q <= bus.src_data;
                cnt_q     <= cnt_q - len_width'(1);
            end
            if (bus.ovf && state_q != S_IDLE && state_q != S_HALT) begin
                ovf_seen_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (bus.ovf) begin
                        state_q <= S_HALT;
                        err_q   <= 1'b1;
                    end else if (start) begin
                        state_q  <= S_SOP;
                        cnt_q    <= pkt_len;
                        len_q    <= pkt_len;
                        busy_q   <= 1'b1;
                        wr_sop_q <= 1'b1;
                    end
                end
                S_SOP: begin
                    if (hdr_en) begin
                        state_q   <= S_DATA;
                        wr_vld_q  <= 1'b1;
                        wr_data_q <= data_width'(len_q);
                    end else if (cnt_q != '0) begin
                        state_q <= S_DATA;
                    end else begin
                        state_q  <= S_EOP;
                        wr_eop_q <= 1'b1;
                        done_q   <= 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt_q == '0) begin
                        state_q  <= S_EOP;
                        wr_eop_q <= 1'b1;
                        done_q   <= 1'b1;
                    end
                end
                S_EOP: begin
                    state_q <= S_GAP;
                    cnt_q   <= len_width'(gap_cycles - 1);
                end
                S_GAP: begin
                    if (cnt_q == '0) begin
                        busy_q <= 1'b0;
                        if (ovf_seen_q || bus.ovf) begin
                            state_q <= S_HALT;
                            err_q   <= 1'b1;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q - len_width'(1);
                    end
                end
                S_HALT: state_q <= S_HALT;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign bus.src_rd  = pop;
    assign bus.wr_sop  = wr_sop_q;
    assign bus.wr_eop  = wr_eop_q;
    assign bus.wr_vld  = wr_vld_q;
    assign bus.wr_data = wr_data_q;

endmodule

// File: tb/tb_pkt_tx.sv
// tb_pkt_tx: directed test-plan packets plus randomized traffic, checked every cycle
// against a timeline model of packet framing (offset from the accepting cycle).
module tb_pkt_tx;
    localparam int DW  = 64;
    localparam int LW  = 9;
    localparam int GAP = 1;
`ifdef PKT_TX_LEN_HDR_EN
    localparam int H = 1;
`else
    localparam int H = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] pkt_len = '0;
    logic          busy;
    logic          done;
    logic          err;

    pkt_tx_if #(.data_width(DW)) bus_if ();

    pkt_tx #(
        .data_width(DW),
        .len_width (LW),
        .gap_cycles(GAP)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .pkt_len(pkt_len),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .bus    (bus_if.master)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] ctl();
        return {busy, done, err, bus_if.wr_sop, bus_if.wr_eop, bus_if.wr_vld, bus_if.src_rd};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Timeline model: a packet accepted in cycle T with length N occupies
    // offsets 1..N+2+H+GAP; every output is a function of that offset.
    bit            m_active = 1'b0;
    bit            m_halt   = 1'b0;
    bit            m_seen   = 1'b0;
    int            m_T      = 0;
    int            m_N      = 0;
    int            m_cyc    = 0;
    logic [DW-1:0] m_last   = '0;
    logic [DW-1:0] m_prev   = '0;

    initial begin : model
        int            k;
        logic          e_busy, e_done, e_err, e_sop, e_eop, e_vld, e_rd;
        logic [DW-1:0] e_data;
        forever begin
            @(negedge clk);
            k      = 0;
            e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0;
            e_sop  = 1'b0; e_eop  = 1'b0; e_vld = 1'b0; e_rd = 1'b0;
            e_data = m_last;
            if (!rst) begin
                e_data = '0;
            end else if (m_halt) begin
                e_err = 1'b1;
            end else if (m_active) begin
                k      = m_cyc - m_T;
                e_busy = 1'b1;
                e_sop  = (k == 1);
                e_vld  = (k >= 2) && (k <= m_N + 1 + H);
                e_eop  = (k == m_N + 2 + H);
                e_done = e_eop;
                e_rd   = (k >= 1 + H) && (k <= m_N + H);
                if (e_vld) e_data = (H == 1 && k == 2) ? DW'(m_N) : m_prev;
            end
            chk("cycle ctl{busy,done,err,sop,eop,vld,rd}", 64'(ctl()),
                64'({e_busy, e_done, e_err, e_sop, e_eop, e_vld, e_rd}));
            chk("cycle wr_data", 64'(bus_if.wr_data), 64'(e_data));
            if (!rst) begin
                m_active = 1'b0;
                m_halt   = 1'b0;
                m_seen   = 1'b0;
                m_last   = '0;
            end else begin
                if (e_vld) m_last = e_data;
                if (m_active) begin
                    if (bus_if.ovf) m_seen = 1'b1;
                    if (k == m_N + 2 + H + GAP) begin
                        m_active = 1'b0;
                        if (m_seen) m_halt = 1'b1;
                    end
                end else if (!m_halt) begin
                    if (bus_if.ovf) begin
                        m_halt = 1'b1;
                    end else if (start) begin
                        m_active = 1'b1;
                        m_T      = m_cyc;
                        m_N      = int'(pkt_len);
                    end
                end
            end
            m_prev = bus_if.src_data;
            m_cyc++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1);
    end

    initial begin : stim
        logic [DW-1:0] tbl [3];
        int            np;
        int            s1, s2, eops, found;

`ifdef PKT_TX_LEN_HDR_EN
        tbl[0] = 64'h11; tbl[1] = 64'h22; tbl[2] = 64'h0; np = 2;
`else
        tbl[0] = 64'hA;  tbl[1] = 64'hB;  tbl[2] = 64'hC; np = 3;
`endif
        bus_if.src_data = 64'h0123_4567_89AB_CDEF;
        bus_if.ovf      = 1'b0;

        @(negedge clk);
        chk("reset ctl", 64'(ctl()), 64'h0);
        chk("reset wr_data", 64'(bus_if.wr_data), 64'h0);
        repeat (2) tick();
        rst = 1'b1;
        tick();

        // First packet from the test plan
        start   = 1'b1;
        pkt_len = LW'(np);
        for (int k = 1; k <= 7; k++) begin
            tick();
            start = 1'b0;
            if (k - 1 - H >= 0 && k - 1 - H < np) bus_if.src_data = tbl[k-1-H];
            else bus_if.src_data = {$urandom, $urandom};
            @(negedge clk);
            if (k == 1) chk("p1 sop@T+1", 64'(bus_if.wr_sop), 64'h1);
`ifdef PKT_TX_LEN_HDR_EN
            if (k == 1) chk("p1 src_rd@T+1", 64'(bus_if.src_rd), 64'h0);
            if (k == 2) chk("p1 src_rd@T+2", 64'(bus_if.src_rd), 64'h1);
            if (k == 2) chk("p1 header word", 64'(bus_if.wr_data), 64'h2);
            if (k == 3) chk("p1 word0", 64'(bus_if.wr_data), 64'h11);
            if (k == 4) chk("p1 word1", 64'(bus_if.wr_data), 64'h22);
            if (k >= 2 && k <= 4) chk("p1 vld", 64'(bus_if.wr_vld), 64'h1);
`else
            if (k == 1) chk("p1 src_rd@T+1", 64'(bus_if.src_rd), 64'h1);
            if (k == 4) chk("p1 src_rd@T+4", 64'(bus_if.src_rd), 64'h0);
            if (k == 2) chk("p1 word0", 64'(bus_if.wr_data), 64'hA);
            if (k == 3) chk("p1 word1", 64'(bus_if.wr_data), 64'hB);
            if (k == 4) chk("p1 word2", 64'(bus_if.wr_data), 64'hC);
            if (k >= 2 && k <= 4) chk("p1 vld", 64'(bus_if.wr_vld), 64'h1);
`endif
            if (k == 5) chk("p1 eop+done@T+5", 64'({bus_if.wr_eop, done, bus_if.wr_vld}), 64'h6);
            if (k == 6) chk("p1 busy in gap", 64'(busy), 64'h1);
            if (k == 7) chk("p1 busy low@T+7", 64'(busy), 64'h0);
        end

        // Empty packet
        tick();
        start   = 1'b1;
        pkt_len = '0;
        for (int k = 1; k <= 4 + H; k++) begin
            tick();
            start = 1'b0;
            @(negedge clk);
            if (k == 1) chk("n0 sop@T+1", 64'(bus_if.wr_sop), 64'h1);
            chk("n0 eop position", 64'(bus_if.wr_eop), 64'(k == 2 + H));
            chk("n0 no src_rd", 64'(bus_if.src_rd), 64'h0);
        end

        // Back-to-back with start held high
        tick();
        start   = 1'b1;
        pkt_len = LW'(2);
        s1 = -1;
        s2 = -1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            @(negedge clk);
            if (bus_if.wr_sop) begin
                if (s1 < 0) s1 = k;
                else if (s2 < 0) s2 = k;
            end
        end
        chk("b2b sop spacing", 64'(s2 - s1), 64'(5 + H + GAP));
        tick();
        start = 1'b0;
        repeat (10) tick();

        // Overflow mid-packet: packet completes, then HALT
        start   = 1'b1;
        pkt_len = LW'(4);
        for (int k = 1; k <= 10; k++) begin
            tick();
            start      = 1'b0;
            bus_if.ovf = (k == 3);
            @(negedge clk);
            chk("ovf eop position", 64'(bus_if.wr_eop), 64'(k == 6 + H));
            if (k >= 9) chk("halt err/busy", 64'({err, busy}), 64'h2);
        end
        for (int k = 1; k <= 4; k++) begin
            tick();
            start = k[0];
            @(negedge clk);
            chk("halt ignores start", 64'({busy, bus_if.wr_sop, bus_if.src_rd, err}), 64'h1);
        end
        tick();
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        chk("reset clears err", 64'(err), 64'h0);
        tick();
        rst = 1'b1;
        tick();

        // Asynchronous reset mid-packet
        bus_if.src_data = 64'hDEAD_BEEF_0000_0001;
        start   = 1'b1;
        pkt_len = LW'(5);
        tick();
        start = 1'b0;
        repeat (2) tick();
        #2;
        rst = 1'b0;
        #1;
        chk("async rst ctl", 64'(ctl()), 64'h0);
        chk("async rst wr_data", 64'(bus_if.wr_data), 64'h0);
        @(negedge clk);
        tick();
        rst = 1'b1;
        tick();
        start = 1'b1;
        eops  = 0;
        for (int k = 1; k <= 9 + H; k++) begin
            tick();
            start = 1'b0;
            bus_if.src_data = {$urandom, $urandom};
            @(negedge clk);
            if (bus_if.wr_eop) eops++;
        end
        chk("post-reset packet eop count", 64'(eops), 64'h1);

        // Maximum length packet
        tick();
        start   = 1'b1;
        pkt_len = '1;
        found   = -1;
        for (int k = 1; k <= 600 && found < 0; k++) begin
            tick();
            start = 1'b0;
            bus_if.src_data = {$urandom, $urandom};
            @(negedge clk);
            if (bus_if.wr_eop) found = k;
        end
        chk("max len eop cycle", 64'(found), 64'((2 ** LW - 1) + 2 + H));
        repeat (3) tick();

        // Randomized traffic with rare overflow and reset
        for (int i = 0; i < 2500; i++) begin
            tick();
            start           = ($urandom_range(3) == 0);
            pkt_len         = ($urandom_range(7) == 0) ? LW'($urandom_range(40)) : LW'($urandom_range(4));
            bus_if.src_data = {$urandom, $urandom};
            bus_if.ovf      = ($urandom_range(400) == 0);
            rst             = ($urandom_range(300) != 0);
        end
        tick();
        rst        = 1'b1;
        start      = 1'b0;
        bus_if.ovf = 1'b0;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pkt_tx.md
Name: pkt_tx

Overview:
- Packet transmitter: the write side of the packet-buffer input protocol (wr_sop/wr_eop/wr_vld/wr_data).
- Pulls payload words from a local source with a pop-style handshake and frames them as one packet for the downstream packet FIFO.
- Watches the FIFO's sticky overflow flag and halts cleanly at a packet boundary when it rises.

Parameters:
data_width, 64, payload word width
len_width, 9, width of pkt_len and of the internal word counter
gap_cycles, 1, idle cycles after EOP before the next start is accepted (must be >= 1)

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
start  input  1  request to send one packet; sampled only in IDLE
pkt_len  input  len_width  payload word count N, latched when start is accepted; 0 is legal (empty packet)
busy  output  1  high from the cycle after acceptance through the last gap cycle
done  output  1  one-cycle pulse, coincident with wr_eop
err  output  1  sticky; overflow was seen, block halted
src_rd  output  1  pop strobe to the source; src_data is valid in the same cycle
src_data  input  data_width  payload word from the source
ovf  input  1  overflow flag from the downstream FIFO
wr_sop  output  1  start-of-packet framing cycle
wr_eop  output  1  end-of-packet framing cycle
wr_vld  output  1  payload word valid
wr_data  output  data_width  payload word

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, counter 0, and all registered outputs 0 (busy, done, err, wr_sop, wr_eop, wr_vld, wr_data). src_rd is decoded from state and is therefore also 0. Reset mid-packet abandons the packet immediately; no EOP is emitted.
- States: IDLE, SOP, DATA, EOP, GAP, HALT.
- IDLE
  - start=1 and ovf=0 at edge T: latch N, go to SOP. busy=1 from T+1.
  - ovf=1: go to HALT, with priority over start.
- SOP (cycle T+1): wr_sop=1, wr_vld=0. Next state is DATA if N>0, else EOP.
- DATA: N cycles, T+2..T+N+1.
  - Each cycle: wr_vld=1, wr_data = word popped on the previous cycle.
  - src_rd=1 in cycles T+1..T+N, exactly N pops.
  - wr_data changes only on vld cycles and holds its value otherwise.
- EOP (cycle T+N+2): wr_eop=1, wr_vld=0, wr_sop=0, done=1.
- Framing cycles are exclusive: sop, vld and eop are never high together.
- GAP: gap_cycles idle cycles, busy=1 and all framing outputs 0. Then IDLE, or HALT if ovf was seen during the packet.
- ovf=1 during SOP/DATA/EOP/GAP:
  - A sticky internal flag is set and the current packet completes with intact framing.
  - After GAP the block enters HALT instead of IDLE.
- HALT: err=1, busy=0, start ignored, src_rd=0. Only reset exits.
- start while busy: ignored, no queuing.
- Counter: down-counter of len_width bits loaded with N. No wrap; N = 2^len_width-1 is the maximum.
- Timing: start-to-SOP latency is 1 cycle. Back-to-back packets occupy N+3+gap_cycles cycles each.

Optional Feature:
- PKT_TX_LEN_HDR_EN defined:
  - One extra vld cycle is inserted right after SOP; its wr_data is pkt_len zero-extended to data_width.
  - Payload vld cycles shift one later: T+3..T+N+2. EOP/done at T+N+3.
  - src_rd is high in cycles T+2..T+N+1, still N pops.
  - For N=0 the header word is still sent.
- Undefined: no header; timing exactly as in Behaviour.

Test Plan:
- Reset then start, N=3, src_data 0xA,0xB,0xC -> sop@T+1; vld with 0xA,0xB,0xC @T+2..T+4; eop+done@T+5; src_rd high T+1..T+3; busy low @T+7 (gap_cycles=1).
- N=0 -> sop@T+1, eop@T+2, no vld, no src_rd.
- Two back-to-back starts held high, N=2 -> second sop exactly 6 cycles after the first; start while busy ignored.
- ovf pulsed at T+3 with N=4 -> packet completes (eop@T+6), then HALT: err=1, later start ignored; reset clears err.
- rst=0 asynchronously at T+3 with N=5 -> all outputs 0 immediately, no eop; new start after release sends a full packet.
- PKT_TX_LEN_HDR_EN, N=2, data 0x11,0x22 -> vld words 0x2, 0x11, 0x22 @T+2..T+4; eop@T+5.
